shift_reg_loader: RTL and testbench

//  Upstream feeder for the serial shift register stage. Accepts a parallel word

---
 rtl/shift_reg_loader.sv | 198 +++++++++++++++++++
 tb/tb_shift_reg_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_loader.sv
// shift_reg_loader: serialises a parallel word onto a serial shift register's control/in pins.
// Latency: accept edge + WIDTH shift cycles + 1 DONE cycle; one word per WIDTH+2 cycles.
// Backpressure: load_ready is low for the whole SHIFT/DONE window; load_valid is ignored while busy.
// Optional macro SHIFT_LOADER_READBACK_EN adds a sticky sr_out readback check in DONE.

module shift_reg_loader #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_dir,
  output logic [1:0]       sr_control,
  output logic             sr_in,
  input  logic [WIDTH-1:0] sr_out,
  output logic             busy,
  output logic             done,
  output logic             readback_err
);

  // FSM encoding kept as plain constants for compatibility with older tooling
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Shift register control codes
  localparam logic [1:0] CTL_HOLD  = 2'b00;
  localparam logic [1:0] CTL_RIGHT = 2'b01;
  localparam logic [1:0] CTL_LEFT  = 2'b10;

  // Counter value during the last shift cycle
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shadow_data;
  logic             shadow_dir;

  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] shadow_rot;
  logic             next_bit;
  logic             first_bit;

  // Rotate one place toward the LSB: bit i+1 moves to bit i, bit 0 wraps to the top.
  function automatic logic [WIDTH-1:0] rot_to_lsb(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = v[(i + 1) % WIDTH];
    end
    return r;
  endfunction

  // Rotate one place toward the MSB: bit i-1 moves to bit i, the top bit wraps to bit 0.
  function automatic logic [WIDTH-1:0] rot_to_msb(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = v[(i + WIDTH - 1) % WIDTH];
    end
    return r;
  endfunction

  // Handshake and status decode straight from state (load_ready is 1 during reset)
  assign load_ready = (state == IDLE);
  assign busy       = (state == SHIFT) || (state == DONE);
  assign accept     = load_valid && load_ready;
  assign last_bit   = (state == SHIFT) && (cnt == CNT_LAST);
  assign first_bit  = load_dir ? load_data[WIDTH-1] : load_data[0];

  // The shadow word is rotated once per shift cycle so the next bit to send always
  // sits at a fixed end; after WIDTH rotations it is back to the captured word,
  // which is what the readback compare in DONE relies on.
  always_comb begin
    shadow_rot = shadow_data;
    next_bit   = 1'b0;
    if (shadow_dir) begin
      shadow_rot = rot_to_msb(shadow_data);
      next_bit   = shadow_rot[WIDTH-1];
    end else begin
      shadow_rot = rot_to_lsb(shadow_data);
      next_bit   = shadow_rot[0];
    end
  end

  // Sequencer: IDLE -> SHIFT (WIDTH cycles) -> DONE (1 cycle) -> IDLE
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= SHIFT;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Shadow copy of the accepted word and direction; inputs may change after acceptance
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_data <= '0;
      shadow_dir  <= 1'b0;
    end else if (accept) begin
      shadow_data <= load_data;
      shadow_dir  <= load_dir;
    end else if (state == SHIFT) begin
      shadow_data <= shadow_rot;
    end
  end

  // Registered pin drive: shift code and serial bit for WIDTH cycles, then hold
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr_control <= CTL_HOLD;
      sr_in      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sr_control <= load_dir ? CTL_LEFT : CTL_RIGHT;
            sr_in      <= first_bit;
          end else begin
            sr_control <= CTL_HOLD;
            sr_in      <= 1'b0;
          end
        end
        SHIFT: begin
          if (last_bit) begin
            sr_control <= CTL_HOLD;
            sr_in      <= 1'b0;
          end else begin
            sr_in <= next_bit;
          end
        end
        default: begin
          sr_control <= CTL_HOLD;
          sr_in      <= 1'b0;
        end
      endcase
    end
  end

  // One-cycle completion pulse covering exactly the DONE state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done <= 1'b0;
    end else begin
      done <= last_bit;
    end
  end

`ifdef SHIFT_LOADER_READBACK_EN
  logic readback_mismatch;

  // By DONE the register has taken all WIDTH bits, so its parallel out must equal the word
  assign readback_mismatch = (state == DONE) && (sr_out != shadow_data);

  // Sticky mismatch flag, cleared only by the next accepted word or reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      readback_err <= 1'b0;
    end else if (accept) begin
      readback_err <= 1'b0;
    end else if (readback_mismatch) begin
      readback_err <= 1'b1;
    end
  end
`else
  logic unused_sr_out;

  assign unused_sr_out = ^sr_out;
  assign readback_err  = 1'b0;
`endif

endmodule

// File: tb/tb_shift_reg_loader.sv
// Directed bench for shift_reg_loader driving a behavioural 8-bit shift register.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_shift_reg_loader;

  logic       clock;
  logic       reset;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_data;
  logic       load_dir;
  logic [1:0] sr_control;
  logic       sr_in;
  logic [7:0] sr_out;
  logic       busy;
  logic       done;
  logic       readback_err;

  logic [7:0] sr_q;
  logic       force_zero;
  int         tests;
  int         fails;
  int         done_cnt;
  int         cyc;
  int         acc_last;
  int         acc_prev;
  int         done_before;

`ifdef SHIFT_LOADER_READBACK_EN
  localparam logic RB_EXP = 1'b1;
`else
  localparam logic RB_EXP = 1'b0;
`endif

  shift_reg_loader #(.WIDTH(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_data    (load_data),
    .load_dir     (load_dir),
    .sr_control   (sr_control),
    .sr_in        (sr_in),
    .sr_out       (sr_out),
    .busy         (busy),
    .done         (done),
    .readback_err (readback_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Downstream shift register: 01 shifts right (in enters at MSB), 10 shifts left
  always @(posedge clock or posedge reset) begin
    if (reset) sr_q <= 8'h00;
    else if (sr_control == 2'b01) sr_q <= {sr_in, sr_q[7:1]};
    else if (sr_control == 2'b10) sr_q <= {sr_q[6:0], sr_in};
  end

  assign sr_out = force_zero ? 8'h00 : sr_q;

  // Cycle counter, done pulse counter and accept timestamps
  always @(posedge clock) begin
    cyc = cyc + 1;
    if (done) done_cnt = done_cnt + 1;
    if (load_valid && load_ready && !reset) begin
      acc_prev = acc_last;
      acc_last = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Load one word from IDLE and follow it through SHIFT and DONE back to IDLE.
  // seq[k] is the k-th bit expected on sr_in.
  task automatic load_word(input logic [7:0] w, input logic d, input logic [7:0] seq,
                           input logic force_rb, input logic exp_err);
    load_valid = 1'b1;
    load_data  = w;
    load_dir   = d;
    @(negedge clock);
    load_valid = 1'b0;
    load_data  = ~w;
    load_dir   = ~d;
    check("rb_clear_on_accept", readback_err, 1'b0);
    for (int k = 0; k < 8; k++) begin
      check("shift_control", sr_control, d ? 2'b10 : 2'b01);
      check("shift_sr_in", sr_in, seq[k]);
      check("shift_ready_low", load_ready, 1'b0);
      @(negedge clock);
    end
    if (force_rb) force_zero = 1'b1;
    check("done_pulse", done, 1'b1);
    check("done_busy", busy, 1'b1);
    check("done_ready_low", load_ready, 1'b0);
    check("done_control_hold", sr_control, 2'b00);
    check("done_sr_in_zero", sr_in, 1'b0);
    check("register_word", sr_q, w);
    @(negedge clock);
    force_zero = 1'b0;
    check("idle_done_low", done, 1'b0);
    check("idle_busy_low", busy, 1'b0);
    check("idle_ready", load_ready, 1'b1);
    check("idle_readback_err", readback_err, exp_err);
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    done_cnt   = 0;
    cyc        = 0;
    acc_last   = 0;
    acc_prev   = 0;
    force_zero = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;
    load_dir   = 1'b0;
    reset      = 1'b1;

    // Reset state
    #2;
    check("rst_control", sr_control, 2'b00);
    check("rst_sr_in", sr_in, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", load_ready, 1'b1);
    check("rst_readback_err", readback_err, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // 1: reset mid-SHIFT after three bits
    load_valid = 1'b1;
    load_data  = 8'hF0;
    load_dir   = 1'b0;
    @(negedge clock);
    load_valid = 1'b0;
    check("abort_pre_control", sr_control, 2'b01);
    check("abort_pre_busy", busy, 1'b1);
    repeat (3) @(negedge clock);
    done_before = done_cnt;
    reset = 1'b1;
    #1;
    check("abort_control", sr_control, 2'b00);
    check("abort_ready", load_ready, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    repeat (12) @(negedge clock);
    check("abort_no_done", done_cnt, done_before);
    check("abort_idle_control", sr_control, 2'b00);

    // 2: 0xA5 shifted right, LSB first: 1,0,1,0,0,1,0,1
    load_word(8'hA5, 1'b0, 8'b1010_0101, 1'b0, 1'b0);

    // 3: 0x3C shifted left, MSB first: 0,0,1,1,1,1,0,0
    load_word(8'h3C, 1'b1, 8'b0011_1100, 1'b0, 1'b0);

    // 4: back-to-back with load_valid held high
    load_valid = 1'b1;
    load_data  = 8'h01;
    load_dir   = 1'b0;
    @(negedge clock);
    load_data  = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      check("b2b_ready_low", load_ready, 1'b0);
      if (i == 8) begin
        check("b2b_done_first", done, 1'b1);
        check("b2b_word_first", sr_q, 8'h01);
      end
      @(negedge clock);
    end
    check("b2b_ready_idle", load_ready, 1'b1);
    @(negedge clock);
    load_valid = 1'b0;
    check("b2b_accept_spacing", acc_last - acc_prev, 10);
    repeat (8) @(negedge clock);
    check("b2b_done_second", done, 1'b1);
    check("b2b_word_second", sr_q, 8'hFF);
    @(negedge clock);

    // 5: corrupted readback on 0x81, then a clean 0x81 clears the flag
    load_word(8'h81, 1'b0, 8'b1000_0001, 1'b1, RB_EXP);
    @(negedge clock);
    check("rb_sticky", readback_err, RB_EXP);
    load_word(8'h81, 1'b0, 8'b1000_0001, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
